// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NUM_REQ requesters.
// One operation is in flight at a time: accept, one execute cycle, then a held response.
package multicore_pkg;
  localparam int unsigned DATA_SIZE = 32;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } t_aluop;
endpackage

module alu_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = multicore_pkg::DATA_SIZE
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  input  multicore_pkg::t_aluop [NUM_REQ-1:0]   i_req_funct,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]     i_req_op_a,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]     i_req_op_b,
  output multicore_pkg::t_aluop                 o_alu_funct,
  output logic [DATA_SIZE-1:0]                  o_alu_op_a,
  output logic [DATA_SIZE-1:0]                  o_alu_op_b,
  input  logic [DATA_SIZE-1:0]                  i_alu_result,
  output logic [NUM_REQ-1:0]                    o_rsp_valid,
  output logic [DATA_SIZE-1:0]                  o_rsp_result,
  input  logic [NUM_REQ-1:0]                    i_rsp_ready,
  output logic                                  o_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             win_found;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && i_req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Gated by reset so no handshake can complete on an edge that reset wins.
  always_comb begin
    o_req_ready = '0;
    if (state == IDLE && !i_rst && win_found) begin
      o_req_ready = NUM_REQ'(1) << win_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      o_rsp_valid  <= '0;
      o_rsp_result <= '0;
      o_alu_funct  <= multicore_pkg::ADD;
      o_alu_op_a   <= '0;
      o_alu_op_b   <= '0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            o_alu_funct <= i_req_funct[win_idx];
            o_alu_op_a  <= i_req_op_a[win_idx];
            o_alu_op_b  <= i_req_op_b[win_idx];
            grant_idx   <= win_idx;
            rr_ptr      <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            o_busy      <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          o_rsp_result <= i_alu_result;
          o_rsp_valid  <= NUM_REQ'(1) << grant_idx;
          state        <= RESP;
        end
        RESP: begin
          if (i_rsp_ready[grant_idx]) begin
            o_rsp_valid <= '0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          o_rsp_valid <= '0;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU stub, accept-time scoreboard,
// and one task per scenario.
module tb_alu_arbiter;
  import multicore_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  t_aluop [3:0]         req_funct;
  logic [3:0][31:0]     req_op_a;
  logic [3:0][31:0]     req_op_b;
  t_aluop               alu_funct;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [31:0]          alu_result;
  logic [3:0]           rsp_valid;
  logic [31:0]          rsp_result;
  logic [3:0]           rsp_ready;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          idx;
    t_aluop      f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          t;
  } sb_t;

  sb_t sb[$];

  alu_arbiter #(.NUM_REQ(4), .DATA_SIZE(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_funct  (req_funct),
    .i_req_op_a   (req_op_a),
    .i_req_op_b   (req_op_b),
    .o_alu_funct  (alu_funct),
    .o_alu_op_a   (alu_a),
    .o_alu_op_b   (alu_b),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_result (rsp_result),
    .i_rsp_ready  (rsp_ready),
    .o_busy       (busy)
  );

  function automatic logic [31:0] alu_ref(t_aluop f, logic [31:0] a, logic [31:0] b);
    case (f)
      ADD:     return a + b;
      SUB:     return a - b;
      SLL:     return a << b[4:0];
      SLT:     return {31'd0, $signed(a) < $signed(b)};
      SLTU:    return {31'd0, a < b};
      XOR:     return a ^ b;
      SRL:     return a >> b[4:0];
      SRA:     return 32'($signed(a) >>> b[4:0]);
      OR:      return a | b;
      AND:     return a & b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_funct, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    next_cycle();
    rst = 1'b0;
    sb.delete();
  endtask

  // Scoreboard: push at accept, check operands in EXEC, latency and data at response.
  task automatic monitor();
    sb_t        e;
    sb_t        ex;
    bit         ex_pend = 1'b0;
    logic [3:0] prev_rsp = '0;
    int         w;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        ex_pend  = 1'b0;
        prev_rsp = '0;
      end else begin
        if (ex_pend) begin
          checks++;
          if (alu_funct !== ex.f || alu_a !== ex.a || alu_b !== ex.b) begin
            failures++;
            $display("FAIL exec_operands: got f=%0d a=%h b=%h expected f=%0d a=%h b=%h",
                     alu_funct, alu_a, alu_b, ex.f, ex.a, ex.b);
          end
          ex_pend = 1'b0;
        end
        if (rsp_valid !== 4'b0000 && prev_rsp === 4'b0000) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
          end else if (rsp_valid !== (4'(1) << sb[0].idx) || (cyc - sb[0].t) != 2) begin
            failures++;
            $display("FAIL rsp_timing: got rsp_valid=%b latency=%0d expected %b latency=2",
                     rsp_valid, cyc - sb[0].t, 4'(1) << sb[0].idx);
          end
        end
        if (sb.size() > 0 && (rsp_valid & rsp_ready & (4'(1) << sb[0].idx)) != 4'b0000) begin
          e = sb.pop_front();
          checks++;
          if (rsp_result !== e.res) begin
            failures++;
            $display("FAIL rsp_result: req%0d got %h expected %h", e.idx, rsp_result, e.res);
          end
        end
        if ((req_ready & req_valid) !== 4'b0000) begin
          checks++;
          if (!$onehot(req_ready)) begin
            failures++;
            $display("FAIL req_ready_onehot: got %b expected one-hot", req_ready);
          end
          w = 0;
          for (int i = 0; i < 4; i++) if (req_ready[i]) w = i;
          e.idx = w;
          e.f   = req_funct[w];
          e.a   = req_op_a[w];
          e.b   = req_op_b[w];
          e.res = alu_ref(req_funct[w], req_op_a[w], req_op_b[w]);
          e.t   = cyc;
          sb.push_back(e);
          ex      = e;
          ex_pend = 1'b1;
        end
        prev_rsp = rsp_valid;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_result !== 32'd0) begin failures++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (alu_funct !== ADD) begin failures++; $display("FAIL reset_alu_funct: got %0d expected ADD", alu_funct); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin failures++; $display("FAIL reset_alu_ops: got a=%h b=%h expected 0", alu_a, alu_b); end
    next_cycle();
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL idle_no_req: got ready=%b busy=%b expected 0000/0", req_ready, busy); end
    next_cycle();
  endtask

  task automatic test_single_op();
    req_valid   = 4'b0001;
    req_funct[0] = ADD;
    req_op_a[0] = 32'd5;
    req_op_b[0] = 32'd7;
    rsp_ready   = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_exec: got busy=%b rsp_valid=%b expected 1/0000", busy, rsp_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'd12) begin failures++; $display("FAIL single_rsp: got valid=%b result=%h expected 0001/0000000c", rsp_valid, rsp_result); end
    next_cycle();
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_done: got valid=%b busy=%b expected 0000/0", rsp_valid, busy); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int grants = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_funct[i] = ADD;
      req_op_a[i]  = 32'h1000 * (i + 1);
      req_op_b[i]  = 32'(i + 7);
    end
    rsp_ready = '1;
    for (int k = 0; k < 16; k++) begin
      req_valid = (grants < 5) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        checks++;
        if (req_ready !== (4'(1) << (grants % 4)) || k != 3 * grants) begin
          failures++;
          $display("FAIL rr_grant: got ready=%b at cycle %0d expected %b at cycle %0d",
                   req_ready, k, 4'(1) << (grants % 4), 3 * grants);
        end
        grants++;
      end
      next_cycle();
    end
    checks++; if (grants != 5) begin failures++; $display("FAIL rr_count: got %0d grants expected 5", grants); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rr_drain: got %0d outstanding expected 0", sb.size()); end
  endtask

  task automatic test_pointer_wrap();
    logic [3:0] pending;
    int         ord[2];
    int         n = 0;
    req_valid    = 4'b1000;
    req_funct[3] = XOR;
    req_op_a[3]  = 32'hF0F0_0000;
    req_op_b[3]  = 32'h0FF0_00FF;
    rsp_ready    = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_grant3: got %b expected 1000", req_ready); end
    next_cycle();
    req_valid = '0;
    repeat (2) begin @(negedge clk); next_cycle(); end
    req_funct[0] = OR;  req_op_a[0] = 32'h0000_00F0; req_op_b[0] = 32'h0000_0F00;
    req_funct[1] = AND; req_op_a[1] = 32'hFFFF_0000; req_op_b[1] = 32'h0F0F_0F0F;
    pending = 4'b0011;
    ord[0] = -1;
    ord[1] = -1;
    for (int k = 0; k < 12; k++) begin
      req_valid = pending;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          if (n < 2) ord[n] = i;
          n++;
          pending[i] = 1'b0;
        end
      end
      next_cycle();
    end
    checks++;
    if (n != 2 || ord[0] != 0 || ord[1] != 1) begin
      failures++;
      $display("FAIL wrap_order: got %0d grants order %0d,%0d expected 2 grants order 0,1", n, ord[0], ord[1]);
    end
  endtask

  task automatic test_backpressure();
    req_valid    = 4'b0100;
    req_funct[2] = SUB;
    req_op_a[2]  = 32'd3;
    req_op_b[2]  = 32'd5;
    rsp_ready    = 4'b0000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant2: got %b expected 0100", req_ready); end
    next_cycle();
    req_valid    = 4'b0010;
    req_funct[1] = ADD;
    req_op_a[1]  = 32'd10;
    req_op_b[1]  = 32'd20;
    rsp_ready    = 4'b1011;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_exec_ready: got %b expected 0000", req_ready); end
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_result !== 32'hFFFF_FFFE || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d got valid=%b result=%h ready=%b expected 0100/fffffffe/0000",
                 k, rsp_valid, rsp_result, req_ready);
      end
      next_cycle();
    end
    rsp_ready = '1;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0100 || req_ready !== 4'b0000) begin failures++; $display("FAIL bp_release: got valid=%b ready=%b expected 0100/0000", rsp_valid, req_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL bp_next_grant: got ready=%b valid=%b expected 0010/0000", req_ready, rsp_valid); end
    next_cycle();
    req_valid = '0;
    repeat (2) begin @(negedge clk); next_cycle(); end
  endtask

  task automatic test_signed_ops();
    t_aluop      tf[4];
    logic [31:0] ta[4];
    logic [31:0] tbv[4];
    logic [31:0] te[4];
    tf[0] = SRA;  ta[0] = 32'h8000_0000; tbv[0] = 32'd4; te[0] = 32'hF800_0000;
    tf[1] = SLT;  ta[1] = 32'hFFFF_FFFF; tbv[1] = 32'd1; te[1] = 32'd1;
    tf[2] = SLTU; ta[2] = 32'hFFFF_FFFF; tbv[2] = 32'd1; te[2] = 32'd0;
    tf[3] = t_aluop'(4'hF); ta[3] = 32'h1234_5678; tbv[3] = 32'h0000_0025; te[3] = 32'd0;
    rsp_ready = '1;
    for (int t = 0; t < 4; t++) begin
      req_valid    = 4'b0001;
      req_funct[0] = tf[t];
      req_op_a[0]  = ta[t];
      req_op_b[0]  = tbv[t];
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL op%0d_ready: got %b expected 0001", t, req_ready); end
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (alu_funct !== tf[t] || alu_a !== ta[t] || alu_b !== tbv[t]) begin
        failures++;
        $display("FAIL op%0d_alu_inputs: got f=%0d a=%h b=%h expected f=%0d a=%h b=%h",
                 t, alu_funct, alu_a, alu_b, tf[t], ta[t], tbv[t]);
      end
      next_cycle();
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL op%0d_rsp_valid: got %b expected 0001", t, rsp_valid); end
      if (t < 3) begin
        checks++; if (rsp_result !== te[t]) begin failures++; $display("FAIL op%0d_result: got %h expected %h", t, rsp_result, te[t]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] pending;
    int         ord[2];
    int         n = 0;
    req_valid    = 4'b0010;
    req_funct[1] = ADD;
    req_op_a[1]  = 32'd1;
    req_op_b[1]  = 32'd2;
    rsp_ready    = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL midop_grant1: got %b expected 0010", req_ready); end
    next_cycle();
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_result !== 32'd0 || alu_a !== 32'd0) begin
      failures++;
      $display("FAIL midop_reset_state: got valid=%b busy=%b result=%h alu_a=%h expected 0000/0/0/0",
               rsp_valid, busy, rsp_result, alu_a);
    end
    checks++; if (sb.size() != 1) begin failures++; $display("FAIL midop_inflight: got %0d outstanding expected 1", sb.size()); end
    sb.delete();
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL midop_dropped: got valid=%b expected 0000", rsp_valid); end
      next_cycle();
    end
    req_funct[0] = SLL; req_op_a[0] = 32'd1;          req_op_b[0] = 32'd31;
    req_funct[3] = SRL; req_op_a[3] = 32'h8000_0000;  req_op_b[3] = 32'd31;
    pending = 4'b1001;
    ord[0] = -1;
    ord[1] = -1;
    for (int k = 0; k < 12; k++) begin
      req_valid = pending;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          if (n < 2) ord[n] = i;
          n++;
          pending[i] = 1'b0;
        end
      end
      next_cycle();
    end
    checks++;
    if (n != 2 || ord[0] != 0 || ord[1] != 3) begin
      failures++;
      $display("FAIL midop_ptr_order: got %0d grants order %0d,%0d expected 2 grants order 0,3", n, ord[0], ord[1]);
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL midop_drain: got %0d outstanding expected 0", sb.size()); end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < 4; i++) begin
      req_funct[i] = ADD;
      req_op_a[i]  = '0;
      req_op_b[i]  = '0;
    end
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
      end
    join_none
    next_cycle();
    test_reset();
    test_single_op();
    test_round_robin();
    test_pointer_wrap();
    test_backpressure();
    test_signed_ops();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
